// File: rtl/stream_vec_writer.sv
// Stream-to-SDRAM vector writer: takes 32-bit stream words, writes them to consecutive word addresses.
// Latency: stream handshake to M_write is 1 cycle; at best one word every 2 cycles.
// Backpressure: one word is held at a time; st_ready stays low until M_waitrequest releases the write.
module stream_vec_writer (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] st_data,
    input  logic        st_valid,
    output logic        st_ready,
    output logic [31:0] M_address,
    output logic [31:0] M_writedata,
    output logic        M_write,
    output logic        M_read,
    input  logic        M_waitrequest,
    input  logic [2:0]  S_address,
    input  logic [31:0] S_writedata,
    input  logic        S_write,
    input  logic        S_read,
    output logic [31:0] S_readdata,
    output logic        S_waitrequest
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q;
    logic [20:0] len_q;
    logic [20:0] wcount_q;
    logic [31:0] csum_q;
    logic        done_q;
    logic [31:0] addr_q;
    logic [31:0] hold_q;

    logic        busy;
    logic        start;
    logic        accept;
    logic        last;
    logic [20:0] wcount_inc;
    logic        unused_ok;

    assign busy       = (state_q != IDLE);
    assign start      = S_write && (S_address == 3'd0) && S_writedata[0] && !busy;
    assign accept     = (state_q == WRITE) && !M_waitrequest;
    assign wcount_inc = wcount_q + 21'd1;
    assign last       = (wcount_inc == len_q);
    assign unused_ok  = ^{S_read, S_writedata[1]};

    // Master and stream outputs come only from registers, never from same-cycle inputs.
    assign st_ready      = (state_q == FETCH);
    assign M_write       = (state_q == WRITE);
    assign M_address     = addr_q;
    assign M_writedata   = hold_q;
    assign M_read        = 1'b0;
    assign S_waitrequest = 1'b0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && (len_q != 21'd0)) state_d = FETCH;
            FETCH:   if (st_valid) state_d = WRITE;
            WRITE:   if (!M_waitrequest) state_d = last ? IDLE : FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        S_readdata = 32'd0;
        case (S_address)
            3'd0:    S_readdata = {30'd0, done_q, busy};
            3'd1:    S_readdata = base_q;
            3'd2:    S_readdata = {11'd0, len_q};
            3'd3:    S_readdata = {11'd0, wcount_q};
            3'd4:    S_readdata = csum_q;
            default: S_readdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= 32'd0;
            len_q    <= 21'd0;
            wcount_q <= 21'd0;
            csum_q   <= 32'd0;
            done_q   <= 1'b0;
            addr_q   <= 32'd0;
            hold_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            // Configuration is frozen while a run is in flight.
            if (S_write && !busy) begin
                case (S_address)
                    3'd1:    base_q <= {S_writedata[31:2], 2'b00};
                    3'd2:    len_q  <= S_writedata[20:0];
                    default: ;
                endcase
            end
            if (start) begin
                wcount_q <= 21'd0;
                csum_q   <= 32'd0;
                done_q   <= (len_q == 21'd0);
                if (len_q != 21'd0) addr_q <= base_q;
            end
            if ((state_q == FETCH) && st_valid) hold_q <= st_data;
            if (accept) begin
                wcount_q <= wcount_inc;
                csum_q   <= csum_q + hold_q;
                addr_q   <= addr_q + 32'd4;
                if (last) done_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_vec_writer.sv
// Randomized bench for stream_vec_writer against a vector-level reference of the expected SDRAM writes.
module tb_stream_vec_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] M_address;
    logic [31:0] M_writedata;
    logic        M_write;
    logic        M_read;
    logic        M_waitrequest;
    logic [2:0]  S_address;
    logic [31:0] S_writedata;
    logic        S_write;
    logic        S_read;
    logic [31:0] S_readdata;
    logic        S_waitrequest;

    stream_vec_writer dut (
        .clk           (clk),
        .rst           (rst),
        .st_data       (st_data),
        .st_valid      (st_valid),
        .st_ready      (st_ready),
        .M_address     (M_address),
        .M_writedata   (M_writedata),
        .M_write       (M_write),
        .M_read        (M_read),
        .M_waitrequest (M_waitrequest),
        .S_address     (S_address),
        .S_writedata   (S_writedata),
        .S_write       (S_write),
        .S_read        (S_read),
        .S_readdata    (S_readdata),
        .S_waitrequest (S_waitrequest)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] stim[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        S_address   = a;
        S_writedata = d;
        S_write     = 1'b1;
        tick();
        S_write   = 1'b0;
        S_address = 3'd0;
    endtask

    task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
        S_address = a;
        S_read    = 1'b1;
        #1;
        d         = S_readdata;
        S_read    = 1'b0;
        S_address = 3'd0;
    endtask

    // Drives one run from stim[], recording every accepted master write.
    task automatic run_vec(input logic [31:0] base_w, input logic [31:0] len_w,
                           input int wait_pct, input int gap_pct,
                           input bit directed, input bit prot, output int ticks);
        int          idx;
        int          nacc;
        int          stalled;
        int          gapped;
        logic        prev_stall;
        logic [31:0] pa;
        logic [31:0] pd;
        idx = 0; nacc = 0; stalled = 0; gapped = 0; prev_stall = 1'b0;
        pa = 32'd0; pd = 32'd0;
        obs_addr.delete();
        obs_data.delete();
        csr_wr(3'd1, base_w);
        csr_wr(3'd2, len_w);
        csr_wr(3'd0, 32'd1);
        check("ready_after_start", {31'd0, st_ready}, 32'd1);
        ticks = 0;
        while (ticks < 2000) begin
            st_valid = (idx < stim.size()) && ($urandom_range(99) >= gap_pct);
            if (directed && idx == 2 && st_ready && gapped < 2) begin
                st_valid = 1'b0;
                gapped++;
            end
            st_data       = st_valid ? stim[idx] : $urandom;
            M_waitrequest = ($urandom_range(99) < wait_pct);
            if (directed && M_write && nacc == 1 && stalled < 3) begin
                M_waitrequest = 1'b1;
                stalled++;
            end
            if (prot && ticks >= 1 && ticks <= 3) begin
                S_write     = 1'b1;
                S_address   = (ticks == 1) ? 3'd1 : (ticks == 2) ? 3'd2 : 3'd0;
                S_writedata = (ticks == 1) ? 32'h0000_2000 : 32'd1;
            end else begin
                S_write   = 1'b0;
                S_address = 3'd0;
            end
            if (prev_stall) begin
                check("stall_write_held", {31'd0, M_write}, 32'd1);
                check("stall_addr", M_address, pa);
                check("stall_data", M_writedata, pd);
            end
            prev_stall = M_write && M_waitrequest;
            pa = M_address;
            pd = M_writedata;
            if (st_valid && st_ready) idx++;
            if (M_write && !M_waitrequest) begin
                obs_addr.push_back(M_address);
                obs_data.push_back(M_writedata);
                nacc++;
            end
            tick();
            ticks++;
            S_write   = 1'b0;
            S_address = 3'd0;
            #1;
            if (S_readdata[0] == 1'b0) break;
        end
        st_valid      = 1'b0;
        M_waitrequest = 1'b0;
        if (ticks >= 2000) check("run_timeout", 32'd0, 32'd1);
    endtask

    // Reference: word i lands at base+4i (mod 2^32) carrying stim[i]; checksum is the plain sum.
    task automatic verify(input string tag, input logic [31:0] base_exp);
        logic [31:0] sum;
        logic [31:0] rd;
        sum = 32'd0;
        check({tag, "_nwrites"}, obs_addr.size(), stim.size());
        for (int i = 0; i < stim.size() && i < obs_addr.size(); i++) begin
            check({tag, "_addr"}, obs_addr[i], base_exp + 32'(4 * i));
            check({tag, "_data"}, obs_data[i], stim[i]);
        end
        foreach (stim[i]) sum = sum + stim[i];
        csr_rd(3'd0, rd); check({tag, "_status"}, rd, 32'd2);
        csr_rd(3'd3, rd); check({tag, "_wcount"}, rd, stim.size());
        csr_rd(3'd4, rd); check({tag, "_csum"}, rd, sum);
        check({tag, "_idle_nowrite"}, {31'd0, M_write}, 32'd0);
    endtask

    initial begin
        int          t;
        logic [31:0] rd;
        logic [31:0] b;
        logic [31:0] lw;
        int          n;

        rst = 1'b1; st_data = 32'd0; st_valid = 1'b0; M_waitrequest = 1'b0;
        S_address = 3'd0; S_writedata = 32'd0; S_write = 1'b0; S_read = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        csr_rd(3'd0, rd); check("reset_status", rd, 32'd0);
        check("reset_maddr", M_address, 32'd0);
        check("reset_mdata", M_writedata, 32'd0);
        check("reset_ties", {30'd0, M_read, S_waitrequest}, 32'd0);

        // Basic run
        stim = '{32'd5, 32'd6, 32'd7};
        run_vec(32'h1000, 32'd3, 0, 0, 1'b0, 1'b0, t);
        check("basic_start_to_done", t + 1, 32'd7);
        verify("basic", 32'h1000);

        // Backpressure: 3 wait cycles on word 2, 2 invalid cycles before word 3
        run_vec(32'h1000, 32'd3, 0, 0, 1'b1, 1'b0, t);
        check("bp_start_to_done", t + 1, 32'd12);
        verify("bp", 32'h1000);

        // Zero length clears counters and finishes without traffic
        csr_wr(3'd2, 32'd0);
        csr_wr(3'd0, 32'd1);
        csr_rd(3'd0, rd); check("zero_status", rd, 32'd2);
        for (int i = 0; i < 3; i++) begin
            check("zero_nowrite", {31'd0, M_write}, 32'd0);
            tick();
        end
        csr_rd(3'd3, rd); check("zero_wcount", rd, 32'd0);
        csr_rd(3'd4, rd); check("zero_csum", rd, 32'd0);

        // Busy protection
        stim = '{32'h11, 32'h22, 32'h33, 32'h44};
        run_vec(32'h3000, 32'd4, 20, 20, 1'b0, 1'b1, t);
        verify("prot", 32'h3000);
        csr_rd(3'd1, rd); check("prot_base", rd, 32'h3000);
        csr_rd(3'd2, rd); check("prot_len", rd, 32'd4);

        // Address wrap and checksum overflow
        stim = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_vec(32'hFFFF_FFF8, 32'd3, 0, 0, 1'b0, 1'b0, t);
        verify("wrap", 32'hFFFF_FFF8);
        csr_rd(3'd4, rd); check("wrap_csum", rd, 32'hFFFF_FFFD);

        // Simultaneous read and write of BASE returns the old value
        S_address = 3'd1; S_writedata = 32'hABCD_0003; S_write = 1'b1; S_read = 1'b1;
        #1;
        check("rw_same_old", S_readdata, 32'hFFFF_FFF8);
        tick();
        S_write = 1'b0; S_read = 1'b0;
        csr_rd(3'd1, rd); check("rw_same_new", rd, 32'hABCD_0000);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            b  = $urandom;
            n  = $urandom_range(1, 8);
            lw = ($urandom & 32'hFFE0_0000) | 32'(n);
            stim.delete();
            for (int i = 0; i < n; i++) stim.push_back($urandom);
            run_vec(b, lw, 30, 30, 1'b0, 1'b0, t);
            verify("rand", b & 32'hFFFF_FFFC);
            csr_rd(3'd1, rd); check("rand_base", rd, b & 32'hFFFF_FFFC);
            csr_rd(3'd2, rd); check("rand_len", rd, 32'(n));
        end

        // Asynchronous reset in the middle of a run
        csr_wr(3'd1, 32'h4000);
        csr_wr(3'd2, 32'd5);
        csr_wr(3'd0, 32'd1);
        st_valid = 1'b1; st_data = 32'h55; M_waitrequest = 1'b1;
        tick();
        check("mid_write_active", {31'd0, M_write}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_ready", {31'd0, st_ready}, 32'd0);
        check("rst_write", {31'd0, M_write}, 32'd0);
        for (int a = 0; a < 5; a++) begin
            csr_rd(3'(a), rd);
            check("rst_csr", rd, 32'd0);
        end
        tick();
        rst = 1'b0;
        M_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_nowrite", {31'd0, M_write}, 32'd0);
        end
        csr_rd(3'd0, rd); check("post_rst_status", rd, 32'd0);
        st_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
